// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Shared constants and state encodings for the UART transmit path.
//  - Board clock and default baud rate, from which the default bit period
//    (clock cycles per UART bit) is derived.
//  - Controller states (IDLE/TX) and serializer bit phases (START/DATA/STOP).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int FRAME_BITS           = UART_DATA_BITS + 2;
   localparam int CLK_HZ               = 100_000_000;
   localparam int BAUD                 = 9600;
   localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

   typedef enum logic {
      CTRL_IDLE,
      CTRL_TX
   } ctrl_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_START,
      PH_DATA,
      PH_STOP
   } tx_phase_e;

endpackage

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//  8N1 serializer. A one-cycle start pulse loads din and sends one frame:
//  a start bit (0), eight data bits LSB first, and a stop bit (1). Each bit
//  lasts exactly CLKS_PER_BIT cycles on the registered RsTx output.
//  Ports:
//   clk    in   board clock
//   rst_n  in   asynchronous active-low reset (RsTx forced high)
//   start  in   one-cycle pulse, accepted only while no frame is running
//   din    in   byte to send, sampled in the start cycle
//   RsTx   out  serial line, idle high
//   done   out  pulses in the last stop-bit cycle of the internal sequence
// ---------------------------------------------------------------------------
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic                      RsTx,
   output logic                      done
);

   localparam int            TW       = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMAX     = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_IDX = 4'(FRAME_BITS - 1);

   logic                      active_q, active_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic [3:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                      rstx_q, rstx_d;
   tx_phase_e                 phase;

   // Bit index 0 is the start bit, LAST_IDX the stop bit.
   always_comb begin
      phase = PH_IDLE;
      if (active_q) begin
         if (idx_q == 4'd0) begin
            phase = PH_START;
         end else if (idx_q == LAST_IDX) begin
            phase = PH_STOP;
         end else begin
            phase = PH_DATA;
         end
      end
   end

   // The start cycle itself counts as timer tick 0 of the start bit; the
   // line value is registered, so RsTx trails the internal sequence by one
   // cycle and done lands one cycle before the stop bit ends on the wire.
   always_comb begin
      active_d = active_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      rstx_d   = 1'b1;
      done     = 1'b0;
      if (!active_q) begin
         if (start) begin
            active_d = 1'b1;
            timer_d  = TW'(1);
            idx_d    = 4'd0;
            shreg_d  = din;
            rstx_d   = 1'b0;
         end
      end else begin
         case (phase)
            PH_START: rstx_d = 1'b0;
            PH_DATA:  rstx_d = shreg_q[0];
            default:  rstx_d = 1'b1;
         endcase
         if (timer_q == TMAX) begin
            timer_d = '0;
            if (phase == PH_DATA) begin
               shreg_d = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
            end
            if (idx_q == LAST_IDX) begin
               active_d = 1'b0;
               idx_d    = 4'd0;
               done     = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   // Serializer state; reset returns the line to idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         timer_q  <= '0;
         idx_q    <= 4'd0;
         shreg_q  <= '0;
         rstx_q   <= 1'b1;
      end else begin
         active_q <= active_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         rstx_q   <= rstx_d;
      end
   end

   assign RsTx = rstx_q;

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//  Shares one 8N1 UART transmitter among N_REQ byte producers. A
//  round-robin arbiter picks one pending requester per frame, latches its
//  byte, acks it for one cycle and starts the serializer.
//  Ports:
//   clk       in   board clock
//   rst_n     in   asynchronous active-low reset
//   req       in   level requests, bit i = byte i valid
//   data      in   flattened bytes, requester i at [8i+7:8i]
//   ack       out  one-cycle pulse, byte of requester i accepted
//   grant_id  out  requester owning the current/last frame
//   busy      out  high while a frame is being transmitted
//   RsTx      out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_REQ-1:0]                  req,
   input  logic [UART_DATA_BITS*N_REQ-1:0]   data,
   output logic [N_REQ-1:0]                  ack,
   output logic [$clog2(N_REQ)-1:0]          grant_id,
   output logic                              busy,
   output logic                              RsTx
);

   localparam int IW = $clog2(N_REQ);
   localparam int DW = UART_DATA_BITS;

   ctrl_state_e   state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [DW-1:0] byte_q, byte_d;
   logic          start_q, start_d;

   logic          found;
   logic [IW-1:0] winner;
   logic [IW-1:0] cand;
   logic [DW-1:0] win_byte;
   logic          core_done;

   // Round-robin scan starting just after the last winner. Candidates are
   // reduced modulo N_REQ so the index never leaves the valid range even
   // when N_REQ is not a power of two.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(rr_ptr_q) + k) % N_REQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Byte of the winning requester.
   always_comb begin
      win_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == IW'(i)) begin
            win_byte = data[i*DW +: DW];
         end
      end
   end

   // Controller: grant and start on one edge in IDLE, then hold TX until the
   // serializer reports the end of the frame. Requests arriving during TX,
   // including in the done cycle, are only looked at in the next IDLE cycle.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      byte_d   = byte_q;
      ack_d    = '0;
      start_d  = 1'b0;
      case (state_q)
         CTRL_IDLE: begin
            if (found) begin
               rr_ptr_d      = winner;
               grant_d       = winner;
               byte_d        = win_byte;
               ack_d[winner] = 1'b1;
               start_d       = 1'b1;
               state_d       = CTRL_TX;
            end
         end
         CTRL_TX: begin
            if (core_done) begin
               state_d = CTRL_IDLE;
            end
         end
         default: state_d = CTRL_IDLE;
      endcase
   end

   // Pointer resets to the last requester so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CTRL_IDLE;
         rr_ptr_q <= IW'(N_REQ - 1);
         grant_q  <= '0;
         ack_q    <= '0;
         byte_q   <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         byte_q   <= byte_d;
         start_q  <= start_d;
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start_q),
      .din  (byte_q),
      .RsTx (RsTx),
      .done (core_done)
   );

   assign ack      = ack_q;
   assign grant_id = grant_q;
   assign busy     = (state_q == CTRL_TX);

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//  Directed bench for the shared UART transmitter. Every granted frame is
//  predicted into a scoreboard queue when the request is driven; a frame
//  monitor pops the prediction on each ack, checks ack/grant_id and then
//  decodes the serial frame at mid-bit. The main sequence checks reset,
//  timing, fairness and the boundary cases.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

   localparam int NReq        = 4;
   localparam int ClksPerBit  = 4;
   localparam int FrameCycles = 10 * ClksPerBit;

   typedef struct {
      int         id;
      logic [7:0] byteVal;
   } expItem_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NReq-1:0] req;
   logic [8*NReq-1:0] data;
   logic [NReq-1:0] ack;
   logic [1:0]      grantId;
   logic            busy;
   logic            rsTx;

   int assertCount = 0;
   int failCount   = 0;
   int cycle       = 0;
   expItem_t sbQ[$];

   uart_tx_sched #(
      .N_REQ       (NReq),
      .CLKS_PER_BIT(ClksPerBit)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .data    (data),
      .ack     (ack),
      .grant_id(grantId),
      .busy    (busy),
      .RsTx    (rsTx)
   );

   // 10 ns board-style clock and a free-running cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // One comparison: counts, asserts, and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the request vector.
   task automatic applyStimulus(input logic [NReq-1:0] reqVal);
      req = reqVal;
   endtask

   task automatic setByte(input int idx, input logic [7:0] val);
      data[idx*8 +: 8] = val;
   endtask

   task automatic expectFrame(input int id, input logic [7:0] val);
      expItem_t item;
      item.id      = id;
      item.byteVal = val;
      sbQ.push_back(item);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Bounded wait for the next ack pulse; returns its cycle number.
   task automatic waitAck(input int bound, input string tag, output int ackCyc);
      bit seen;
      seen   = 1'b0;
      ackCyc = -1;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (ack !== '0) begin
            seen   = 1'b1;
            ackCyc = cycle;
         end
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   // Bounded wait for the transmitter to go idle.
   task automatic waitIdle(input int bound, input string tag);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < bound && !idle; i++) begin
         @(negedge clk);
         if (busy === 1'b0) idle = 1'b1;
      end
      checkOutput(tag, 32'(idle), 32'd1);
   endtask

   // Scoreboard consumer: on each ack, check the prediction and decode the
   // frame. A reset during the frame abandons the decode.
   initial begin : frameMonitor
      expItem_t   item;
      logic [9:0] frameBits;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && ack !== '0) begin
            checkOutput("sb_nonempty", 32'(sbQ.size() > 0), 32'd1);
            if (sbQ.size() > 0) begin
               item = sbQ.pop_front();
               checkOutput("ack_vector", 32'(ack), 32'(1 << item.id));
               checkOutput("grant_id", 32'(grantId), 32'(item.id));
               frameBits = '0;
               aborted   = 1'b0;
               for (int c = 1; c < FrameCycles; c++) begin
                  @(negedge clk);
                  if (rst_n !== 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (c % ClksPerBit == ClksPerBit / 2 + 1) begin
                     frameBits[c / ClksPerBit] = rsTx;
                  end
               end
               if (!aborted) begin
                  checkOutput("frame_bits", 32'(frameBits), 32'({1'b1, item.byteVal, 1'b0}));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin : mainSequence
      int  a [5];
      int  ackCyc;
      int  firstAck;
      int  n;
      logic rstxAtStart;
      bit  sawAck;
      bit  lineNotIdle;

      rst_n = 1'b0;
      req   = '0;
      data  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_rstx", 32'(rsTx), 32'd1);
      checkOutput("reset_ack", 32'(ack), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_grant", 32'(grantId), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single byte A5 from requester 0");
      setByte(0, 8'hA5);
      expectFrame(0, 8'hA5);
      applyStimulus(4'b0001);
      waitAck(5, "t1_ack_seen", ackCyc);
      applyStimulus(4'b0000);
      n = 0;
      rstxAtStart = 1'b1;
      while (busy === 1'b1 && n < 60) begin
         n++;
         @(negedge clk);
         if (n == 1) rstxAtStart = rsTx;
      end
      checkOutput("t1_start_after_ack", 32'(rstxAtStart), 32'd0);
      checkOutput("t1_busy_cycles", 32'(n), 32'(FrameCycles));
      checkOutput("t1_ack_single", 32'(ack), 32'd0);

      $display("[TB] all requesters held");
      doReset();
      setByte(0, 8'h11);
      setByte(1, 8'h22);
      setByte(2, 8'h33);
      setByte(3, 8'h44);
      expectFrame(0, 8'h11);
      expectFrame(1, 8'h22);
      expectFrame(2, 8'h33);
      expectFrame(3, 8'h44);
      expectFrame(0, 8'h11);
      applyStimulus(4'b1111);
      for (int i = 0; i < 5; i++) begin
         waitAck(FrameCycles + 10, "t2_ack_seen", a[i]);
      end
      applyStimulus(4'b0000);
      for (int i = 1; i < 5; i++) begin
         checkOutput("t2_frame_pitch", 32'(a[i] - a[i-1]), 32'(FrameCycles + 1));
      end
      waitIdle(FrameCycles + 10, "t2_idle");

      $display("[TB] request raised mid-frame");
      setByte(0, 8'h3C);
      expectFrame(0, 8'h3C);
      applyStimulus(4'b0001);
      waitAck(5, "t3_first_ack", firstAck);
      applyStimulus(4'b0000);
      repeat (15) @(negedge clk);
      setByte(0, 8'hFF);
      setByte(2, 8'h5A);
      expectFrame(2, 8'h5A);
      applyStimulus(4'b0100);
      waitAck(FrameCycles + 10, "t3_second_ack", ackCyc);
      applyStimulus(4'b0000);
      checkOutput("t3_grant_after_done", 32'(ackCyc - firstAck), 32'(FrameCycles + 1));
      checkOutput("t3_grant_id", 32'(grantId), 32'd2);
      waitIdle(FrameCycles + 10, "t3_idle");

      $display("[TB] withdrawn request");
      setByte(3, 8'h96);
      expectFrame(3, 8'h96);
      applyStimulus(4'b1000);
      waitAck(5, "t4_ack_seen", ackCyc);
      applyStimulus(4'b0000);
      repeat (10) @(negedge clk);
      applyStimulus(4'b0010);
      repeat (3) @(negedge clk);
      applyStimulus(4'b0000);
      waitIdle(FrameCycles + 10, "t4_idle");
      sawAck      = 1'b0;
      lineNotIdle = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ack !== '0) sawAck = 1'b1;
         if (rsTx !== 1'b1) lineNotIdle = 1'b1;
      end
      checkOutput("t4_no_ack", 32'(sawAck), 32'd0);
      checkOutput("t4_line_idle", 32'(lineNotIdle), 32'd0);

      $display("[TB] reset mid-frame");
      setByte(0, 8'hC3);
      expectFrame(0, 8'hC3);
      applyStimulus(4'b0001);
      waitAck(5, "t5_ack_seen", ackCyc);
      applyStimulus(4'b0000);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_rstx_forced", 32'(rsTx), 32'd1);
      checkOutput("t5_busy_cleared", 32'(busy), 32'd0);
      checkOutput("t5_no_ack", 32'(ack), 32'd0);
      setByte(3, 8'hE7);
      expectFrame(3, 8'hE7);
      applyStimulus(4'b1000);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      waitAck(5, "t5_ack_after_reset", ackCyc);
      applyStimulus(4'b0000);
      checkOutput("t5_grant_id", 32'(grantId), 32'd3);
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         n++;
         @(negedge clk);
      end
      checkOutput("t5_busy_cycles", 32'(n), 32'(FrameCycles));

      $display("[TB] fairness after reset");
      doReset();
      setByte(1, 8'h81);
      setByte(3, 8'h7E);
      expectFrame(1, 8'h81);
      expectFrame(3, 8'h7E);
      expectFrame(1, 8'h81);
      applyStimulus(4'b1010);
      waitAck(5, "t6_ack1", ackCyc);
      checkOutput("t6_grant1", 32'(grantId), 32'd1);
      waitAck(FrameCycles + 10, "t6_ack2", ackCyc);
      checkOutput("t6_grant2", 32'(grantId), 32'd3);
      waitAck(FrameCycles + 10, "t6_ack3", ackCyc);
      applyStimulus(4'b0000);
      checkOutput("t6_grant3", 32'(grantId), 32'd1);
      waitIdle(FrameCycles + 10, "t6_idle");
      repeat (5) @(negedge clk);

      checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
